// File: rtl/fp_add_pkg.sv
// Shared types and constants for the FP adder control path.
package fp_add_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      HOLD,
      DRAIN
   } state_t;

   localparam int          FP_WIDTH    = 32;
   localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
   localparam int          DEF_TIMEOUT = 48;
   localparam int          TIMER_W     = 7;

endpackage

// File: rtl/fp_add_sequencer.sv
// Handshake front/back end around the fixed-latency FP adder delay stage:
// launches one add at a time, waits for done, and parks the sum on a result port.
module fp_add_sequencer
   import fp_add_pkg::*;
#(
   parameter int               WIDTH   = FP_WIDTH,
   parameter int               TIMEOUT = DEF_TIMEOUT,
   parameter logic [WIDTH-1:0] QNAN    = WIDTH'(FP_QNAN)
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_start,
   input  logic             add_done,
   input  logic [WIDTH-1:0] add_sum,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_timeout,
   output logic             busy
);

   localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT - 1);

   state_t             state;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_inc;
   logic [WIDTH-1:0]   hold_sum;
   logic               hold_timeout;
   logic               hold_pending;
   logic               done_seen;
   logic               slot_free;

   assign op_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign slot_free = !res_valid || res_ready;
   assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state        <= IDLE;
         timer        <= '0;
         add_a        <= '0;
         add_b        <= '0;
         add_start    <= 1'b0;
         res_valid    <= 1'b0;
         res_data     <= '0;
         res_timeout  <= 1'b0;
         hold_sum     <= '0;
         hold_timeout <= 1'b0;
         hold_pending <= 1'b0;
         done_seen    <= 1'b0;
      end else begin
         add_start <= 1'b0;
         // NOTE: a later non-blocking load in this block overrides this clear,
         // which is how a same-cycle reload keeps res_valid high.
         if (res_valid && res_ready) res_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (op_valid) begin
                  add_a     <= op_a;
                  add_b     <= op_b;
                  add_start <= 1'b1;
                  state     <= LAUNCH;
               end
            end

            LAUNCH: begin
               timer <= '0;
               state <= WAIT;
            end

            WAIT: begin
               timer <= timer_inc;
               if (add_done) begin
                  timer <= '0;
                  if (slot_free) begin
                     res_data    <= add_sum;
                     res_valid   <= 1'b1;
                     res_timeout <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     hold_sum     <= add_sum;
                     hold_timeout <= 1'b0;
                     state        <= HOLD;
                  end
               end else if (timer == TIMER_LIMIT) begin
                  timer     <= '0;
                  done_seen <= 1'b0;
                  state     <= DRAIN;
                  if (slot_free) begin
                     res_data    <= QNAN;
                     res_valid   <= 1'b1;
                     res_timeout <= 1'b1;
                  end else begin
                     hold_sum     <= QNAN;
                     hold_timeout <= 1'b1;
                     hold_pending <= 1'b1;
                  end
               end
            end

            HOLD: begin
               if (res_ready) begin
                  res_data    <= hold_sum;
                  res_timeout <= hold_timeout;
                  res_valid   <= 1'b1;
                  state       <= IDLE;
               end
            end

            // A late done may still be in flight; it must not reach the next operation.
            DRAIN: begin
               timer <= timer_inc;
               if (add_done) done_seen <= 1'b1;
               if (hold_pending) begin
                  if (res_ready) begin
                     res_data     <= hold_sum;
                     res_timeout  <= hold_timeout;
                     res_valid    <= 1'b1;
                     hold_pending <= 1'b0;
                  end
               end else if (add_done || done_seen || timer >= TIMER_LIMIT) begin
                  timer     <= '0;
                  done_seen <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed and randomized checks of fp_add_sequencer against a queue-based result model
// and a behavioural stand-in for the adder delay stage.
module tb_fp_add_sequencer;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam int          TIMEOUT = 48;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_start;
   logic        add_done = 1'b0;
   logic [31:0] add_sum  = '0;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_timeout;
   logic        busy;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_results = 0;
   int          n_expected = 0;
   logic [32:0] exp_q[$];
   int          lat_q[$];
   bit          rand_mode = 1'b0;
   int          spur_req  = 0;

   always #5 clk_in = ~clk_in;

   fp_add_sequencer #(
      .WIDTH   (32),
      .TIMEOUT (TIMEOUT),
      .QNAN    (QNAN)
   ) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_start   (add_start),
      .add_done    (add_done),
      .add_sum     (add_sum),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_timeout (res_timeout),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Stand-in for the FP adder: known IEEE pairs for the directed cases, any function otherwise.
   function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40A0_0000;
      return a + b;
   endfunction

   // Done arriving in WAIT cycle 1..TIMEOUT yields the sum; anything later (or never) times out.
   function automatic logic [32:0] expect_res(input logic [31:0] a, input logic [31:0] b, input int lat);
      if (lat >= 1 && lat <= TIMEOUT) return {1'b0, fake_add(a, b)};
      return {1'b1, QNAN};
   endfunction

   task automatic tick;
      @(negedge clk_in);
      #1;
      if (rand_mode) res_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic count_until_valid(output int n);
      n = 0;
      while (!res_valid && n < 200) begin
         tick;
         n++;
      end
   endtask

   task automatic count_until_ready(output int n);
      n = 0;
      while (!op_ready && n < 200) begin
         tick;
         n++;
      end
   endtask

   // lat = cycles from the add_start cycle to add_done; 0 means the done never comes.
   task automatic send_op(input logic [31:0] a, input logic [31:0] b, input int lat);
      int n;
      n = 0;
      while (!op_ready && n < 400) begin
         tick;
         n++;
      end
      if (!op_ready) check("op_ready_wait", op_ready, 1);
      op_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      lat_q.push_back(lat);
      exp_q.push_back(expect_res(a, b, lat));
      n_expected++;
      tick;
      op_valid = 1'b0;
   endtask

   // Delay-stage model: answers add_start after the queued latency; shares the reset.
   initial begin : adder_stub
      int          cnt;
      int          spur_done;
      logic [31:0] pend_sum;
      cnt       = 0;
      spur_done = 0;
      pend_sum  = '0;
      forever begin
         @(negedge clk_in);
         #3;
         add_done = 1'b0;
         if (rst_in) begin
            cnt = 0;
            lat_q.delete();
         end else begin
            if (spur_req != spur_done) begin
               add_done  = 1'b1;
               add_sum   = 32'hDEAD_BEEF;
               spur_done = spur_req;
            end
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  add_done = 1'b1;
                  add_sum  = pend_sum;
               end
            end
            if (add_start) begin
               cnt      = (lat_q.size() > 0) ? lat_q.pop_front() : 34;
               pend_sum = fake_add(add_a, add_b);
            end
            if (!add_done) add_sum = $urandom;
         end
      end
   end

   // Result scoreboard plus stability of a stalled result.
   initial begin : result_monitor
      bit          stalled;
      logic [32:0] prev;
      logic [32:0] e;
      stalled = 1'b0;
      prev    = '0;
      forever begin
         @(negedge clk_in);
         #4;
         if (rst_in) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               check("stall_valid", res_valid, 1);
               check("stall_data", {res_timeout, res_data}, prev);
            end
            if (res_valid && res_ready) begin
               check("result_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("result", {res_timeout, res_data}, e);
                  n_results++;
               end
            end
            stalled = res_valid && !res_ready;
            prev    = {res_timeout, res_data};
         end
      end
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n;
      int lat_tab[8];
      bit seen;
      lat_tab = '{34, 34, 1, 20, 48, 49, 0, 70};
      rst_in    = 1'b1;
      op_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      res_ready = 1'b1;
      tick;
      tick;
      check("rst_op_ready", op_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_add_start", add_start, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_timeout", res_timeout, 0);
      check("rst_add_a", add_a, 0);
      check("rst_add_b", add_b, 0);
      rst_in = 1'b0;
      tick;

      // Basic add with a ready consumer.
      send_op(32'h3F80_0000, 32'h4000_0000, 34);
      check("basic_start", add_start, 1);
      check("basic_add_a", add_a, 32'h3F80_0000);
      check("basic_add_b", add_b, 32'h4000_0000);
      check("basic_busy", busy, 1);
      check("basic_op_ready", op_ready, 0);
      tick;
      check("basic_start_width", add_start, 0);
      count_until_valid(n);
      check("basic_latency", n + 1, 35);
      check("basic_data", res_data, 32'h4040_0000);
      check("basic_timeout", res_timeout, 0);
      check("basic_ready_back", op_ready, 1);
      tick;

      // Backpressure: first result parks on the port, second waits in HOLD.
      res_ready = 1'b0;
      send_op(32'h3F80_0000, 32'h4000_0000, 34);
      send_op(32'h4000_0000, 32'h4040_0000, 34);
      repeat (40) tick;
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, 32'h4040_0000);
      check("bp_op_ready", op_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_add_a_stable", add_a, 32'h4000_0000);
      res_ready = 1'b1;
      tick;
      check("bp_second_valid", res_valid, 1);
      check("bp_second_data", res_data, 32'h40A0_0000);
      check("bp_idle", op_ready, 1);
      tick;
      check("bp_drained", res_valid, 0);

      // Timeout: the done never arrives.
      send_op(32'h3F80_0000, 32'h4000_0000, 0);
      count_until_valid(n);
      check("to_latency", n, TIMEOUT + 1);
      check("to_data", res_data, QNAN);
      check("to_flag", res_timeout, 1);
      count_until_ready(n);
      check("to_drain_len", n, TIMEOUT);

      // Late done during DRAIN ends the drain early and yields no extra result.
      send_op(32'h3F80_0000, 32'h4000_0000, 50);
      count_until_valid(n);
      check("late_latency", n, TIMEOUT + 1);
      check("late_flag", res_timeout, 1);
      count_until_ready(n);
      check("late_drain_len", n, 2);
      send_op(32'h4000_0000, 32'h4040_0000, 34);
      count_until_valid(n);
      check("late_next_latency", n, 35);
      check("late_next_data", res_data, 32'h40A0_0000);
      check("late_next_flag", res_timeout, 0);
      tick;

      // Reset in WAIT cycle 10 abandons the operation.
      send_op(32'h3F80_0000, 32'h4000_0000, 34);
      repeat (10) tick;
      rst_in = 1'b1;
      void'(exp_q.pop_back());
      n_expected--;
      tick;
      rst_in = 1'b0;
      check("mid_rst_add_a", add_a, 0);
      check("mid_rst_add_b", add_b, 0);
      check("mid_rst_start", add_start, 0);
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_data", res_data, 0);
      check("mid_rst_timeout", res_timeout, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_op_ready", op_ready, 1);
      seen = 1'b0;
      repeat (60) begin
         tick;
         if (res_valid) seen = 1'b1;
      end
      check("mid_rst_no_result", seen, 0);
      send_op(32'h4000_0000, 32'h4040_0000, 34);
      count_until_valid(n);
      check("post_rst_latency", n, 35);
      check("post_rst_data", res_data, 32'h40A0_0000);
      tick;

      // Spurious done while idle is ignored.
      spur_req++;
      repeat (4) tick;
      check("spur_valid", res_valid, 0);
      check("spur_busy", busy, 0);
      check("spur_op_ready", op_ready, 1);

      // Randomized operands, latencies and consumer backpressure.
      rand_mode = 1'b1;
      for (int i = 0; i < 30; i++) begin
         send_op($urandom, $urandom, lat_tab[$urandom_range(0, 7)]);
      end
      rand_mode = 1'b0;
      res_ready = 1'b1;
      n = 0;
      while ((exp_q.size() > 0 || !op_ready) && n < 400) begin
         tick;
         n++;
      end
      tick;
      check("final_queue_empty", exp_q.size(), 0);
      check("final_result_count", n_results, n_expected);
      check("final_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
